// File: rtl/gpio_input.sv
// Debounced GPIO input port with a three-register CPU window (Stable, EdgeStatus, IrqEnable).
// Rising edges of the debounced pins latch into EdgeStatus and raise a level interrupt.
module gpio_input #(
    parameter int         Width         = 31,
    parameter logic [8:0] BaseAddress   = 9'd64,
    parameter int         DebounceCount = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [Width-1:0] DataInput_Pins,
    input  logic [8:0]       AddressIO,
    input  logic             ReadIO,
    input  logic             WriteIO,
    input  logic [31:0]      DataOutput,
    output logic [31:0]      DataInputTowardMicro,
    output logic             Irq
);

    localparam int CntWidth = $clog2(DebounceCount + 1);
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(DebounceCount);

    logic [Width-1:0]    syncStage1;
    logic [Width-1:0]    syncStage2;
    logic [Width-1:0]    stable;
    logic [Width-1:0]    stableNext;
    logic [Width-1:0]    edgeStatus;
    logic [Width-1:0]    irqEnable;
    logic [Width-1:0]    riseEvent;
    logic [Width-1:0]    clearMask;
    logic [Width-1:0]    writeData;
    logic [CntWidth-1:0] debounceCnt     [Width];
    logic [CntWidth-1:0] debounceCntNext [Width];
    logic                selStable;
    logic                selEdge;
    logic                selEnable;
    logic [31:0]         readValue;
    logic                unusedDataBits;

    assign selStable = (AddressIO == BaseAddress);
    assign selEdge   = (AddressIO == BaseAddress + 9'd1);
    assign selEnable = (AddressIO == BaseAddress + 9'd2);
    assign writeData = DataOutput[Width-1:0];

    // Bits of the write bus above Width have no register behind them.
    assign unusedDataBits = ^DataOutput;

    // A pin is accepted only after DebounceCount consecutive synchronized samples disagree with Stable.
    always_comb begin
        stableNext = stable;
        for (int n = 0; n < Width; n++) begin
            debounceCntNext[n] = '0;
            if (syncStage2[n] != stable[n]) begin
                if (debounceCnt[n] + 1'b1 == CntLimit) begin
                    stableNext[n] = syncStage2[n];
                end else begin
                    debounceCntNext[n] = debounceCnt[n] + 1'b1;
                end
            end
        end
    end

    assign riseEvent = stableNext & ~stable;
    assign clearMask = (WriteIO && selEdge) ? writeData : '0;

    always_comb begin
        readValue = 32'h0;
        if (selStable) begin
            readValue = 32'(stable);
        end else if (selEdge) begin
            readValue = 32'(edgeStatus);
        end else if (selEnable) begin
            readValue = 32'(irqEnable);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            syncStage1 <= '0;
            syncStage2 <= '0;
            stable     <= '0;
            for (int n = 0; n < Width; n++) begin
                debounceCnt[n] <= '0;
            end
        end else begin
            syncStage1 <= DataInput_Pins;
            syncStage2 <= syncStage1;
            stable     <= stableNext;
            for (int n = 0; n < Width; n++) begin
                debounceCnt[n] <= debounceCntNext[n];
            end
        end
    end

    // A fresh rising edge outranks a simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            edgeStatus           <= '0;
            irqEnable            <= '0;
            DataInputTowardMicro <= 32'h0;
            Irq                  <= 1'b0;
        end else begin
            edgeStatus <= (edgeStatus & ~clearMask) | riseEvent;
            if (WriteIO && selEnable) begin
                irqEnable <= writeData;
            end
            Irq <= |(edgeStatus & irqEnable);
            if (ReadIO) begin
                DataInputTowardMicro <= readValue;
            end
        end
    end

endmodule

// File: tb/tb_gpio_input.sv
// Self-checking bench for gpio_input: window-based debounce model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gpio_input;

    localparam int         W    = 31;
    localparam int         D    = 16;
    localparam logic [8:0] BASE = 9'd64;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [W-1:0]  DataInput_Pins;
    logic [8:0]    AddressIO;
    logic          ReadIO;
    logic          WriteIO;
    logic [31:0]   DataOutput;
    logic [31:0]   DataInputTowardMicro;
    logic          Irq;

    int compared   = 0;
    int mismatched = 0;

    gpio_input #(
        .Width(W),
        .BaseAddress(BASE),
        .DebounceCount(D)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .DataInput_Pins(DataInput_Pins),
        .AddressIO(AddressIO),
        .ReadIO(ReadIO),
        .WriteIO(WriteIO),
        .DataOutput(DataOutput),
        .DataInputTowardMicro(DataInputTowardMicro),
        .Irq(Irq)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: Stable flips when the last D samples past the synchronizer all disagree with it.
    logic [W-1:0] mSync1, mSync2, mStable, mEdge, mEn;
    logic [W-1:0] preStable, preEdge, preEn, newStable, rise, clr;
    logic [W-1:0] hist[$];
    logic [31:0]  mData;
    logic         mIrq;
    logic         started = 1'b0;
    bit           allDiff;

    always @(posedge CLK) begin
        if (Reset) begin
            mSync1 = '0; mSync2 = '0; mStable = '0; mEdge = '0; mEn = '0;
            mData = 32'h0; mIrq = 1'b0;
            hist.delete();
            started = 1'b1;
        end else begin
            preStable = mStable;
            preEdge   = mEdge;
            preEn     = mEn;
            if (ReadIO) begin
                if (AddressIO == BASE) mData = 32'(preStable);
                else if (AddressIO == BASE + 9'd1) mData = 32'(preEdge);
                else if (AddressIO == BASE + 9'd2) mData = 32'(preEn);
                else mData = 32'h0;
            end
            hist.push_back(mSync2);
            if (hist.size() > D) void'(hist.pop_front());
            newStable = preStable;
            if (hist.size() == D) begin
                for (int n = 0; n < W; n++) begin
                    allDiff = 1'b1;
                    foreach (hist[i]) if (hist[i][n] == preStable[n]) allDiff = 1'b0;
                    if (allDiff) newStable[n] = ~preStable[n];
                end
            end
            rise  = newStable & ~preStable;
            clr   = (WriteIO && AddressIO == BASE + 9'd1) ? DataOutput[W-1:0] : '0;
            mEdge = (preEdge & ~clr) | rise;
            if (WriteIO && AddressIO == BASE + 9'd2) mEn = DataOutput[W-1:0];
            mIrq    = |(preEdge & preEn);
            mStable = newStable;
            mSync2  = mSync1;
            mSync1  = DataInput_Pins;
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            checkOutput("model rdata", DataInputTowardMicro, mData);
            checkOutput("model irq", 32'(Irq), 32'(mIrq));
        end
    end

    task automatic applyStimulus(input logic [8:0] addr, input logic rd, input logic wr, input logic [31:0] data);
        AddressIO  = addr;
        ReadIO     = rd;
        WriteIO    = wr;
        DataOutput = data;
        @(posedge CLK);
        #1;
        ReadIO  = 1'b0;
        WriteIO = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(AddressIO, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic readCheck(input string name, input logic [8:0] addr, input logic [31:0] expected);
        applyStimulus(addr, 1'b1, 1'b0, 32'h0);
        checkOutput(name, DataInputTowardMicro, expected);
    endtask

    initial begin
        Reset = 1'b1; DataInput_Pins = '0; AddressIO = '0;
        ReadIO = 1'b0; WriteIO = 1'b0; DataOutput = 32'h0;
        idle(3);
        Reset = 1'b0;
        idle(4);
        readCheck("reset stable", BASE, 32'h0);
        readCheck("reset edge", BASE + 9'd1, 32'h0);
        readCheck("reset enable", BASE + 9'd2, 32'h0);
        checkOutput("reset irq", 32'(Irq), 32'h0);

        // Pin 3 rises; continuous reads of Stable show it one cycle after edge 18.
        DataInput_Pins[3] = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            applyStimulus(BASE, 1'b1, 1'b0, 32'h0);
            if (k == 18) checkOutput("stable before 18", DataInputTowardMicro, 32'h0);
            if (k == 19) checkOutput("stable bit3", DataInputTowardMicro, 32'h8);
        end
        readCheck("edge bit3", BASE + 9'd1, 32'h8);

        // 10-cycle glitch on pin 5 must be rejected.
        DataInput_Pins[5] = 1'b1;
        idle(10);
        DataInput_Pins[5] = 1'b0;
        idle(30);
        readCheck("glitch stable", BASE, 32'h8);
        readCheck("glitch edge", BASE + 9'd1, 32'h8);
        checkOutput("glitch irq", 32'(Irq), 32'h0);

        applyStimulus(BASE + 9'd2, 1'b0, 1'b1, 32'h8);
        checkOutput("irq latency", 32'(Irq), 32'h0);
        idle(1);
        checkOutput("irq raised", 32'(Irq), 32'h1);
        applyStimulus(BASE + 9'd1, 1'b0, 1'b1, 32'h8);
        checkOutput("irq after clear", 32'(Irq), 32'h1);
        idle(1);
        checkOutput("irq dropped", 32'(Irq), 32'h0);
        readCheck("edge cleared", BASE + 9'd1, 32'h0);

        // Pin 0 rise lands on edge 18, the same edge as a clear of bit 0.
        DataInput_Pins[0] = 1'b1;
        idle(17);
        applyStimulus(BASE + 9'd1, 1'b0, 1'b1, 32'h1);
        readCheck("set wins", BASE + 9'd1, 32'h1);
        applyStimulus(BASE + 9'd1, 1'b0, 1'b1, 32'h1);
        readCheck("bit0 cleared", BASE + 9'd1, 32'h0);

        applyStimulus(BASE + 9'd2, 1'b1, 1'b1, 32'hFFFF_FFFF);
        checkOutput("rw pre-write", DataInputTowardMicro, 32'h8);
        readCheck("enable width", BASE + 9'd2, 32'h7FFF_FFFF);
        applyStimulus(BASE, 1'b0, 1'b1, 32'hFFFF_FFFF);
        readCheck("stable read only", BASE, 32'h9);
        readCheck("unmapped read", BASE + 9'd7, 32'h0);
        applyStimulus(BASE + 9'd7, 1'b0, 1'b1, 32'h0);
        readCheck("unmapped write", BASE + 9'd2, 32'h7FFF_FFFF);

        // Reset mid-debounce of pin 7, with pins 0 and 3 held high through release.
        DataInput_Pins[7] = 1'b1;
        idle(10);
        Reset = 1'b1;
        DataInput_Pins[7] = 1'b0;
        applyStimulus(BASE + 9'd2, 1'b1, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(BASE + 9'd2, 1'b1, 1'b1, 32'hFFFF_FFFF);
        checkOutput("reset rdata", DataInputTowardMicro, 32'h0);
        checkOutput("reset irq mid", 32'(Irq), 32'h0);
        Reset = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            applyStimulus(BASE, 1'b1, 1'b0, 32'h0);
            if (k == 18) checkOutput("post-reset before 18", DataInputTowardMicro, 32'h0);
            if (k == 19) checkOutput("post-reset stable", DataInputTowardMicro, 32'h9);
        end
        readCheck("post-reset edge", BASE + 9'd1, 32'h9);
        readCheck("reset write ignored", BASE + 9'd2, 32'h0);
        checkOutput("post-reset irq", 32'(Irq), 32'h0);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gpio_input.md
GPIO_INPUT -- requirements
Module: gpio_input

Interface
REQ-001 SHALL have parameter Width, default 31, giving the number of input pins (1..32).
REQ-002 SHALL have parameter BaseAddress, default 9'd64, giving the first of three IO addresses.
REQ-003 SHALL have parameter DebounceCount, default 16, giving the stable-cycle count required before a pin change is accepted (>=1).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port DataInput_Pins, input, Width bits: asynchronous external pins.
REQ-007 SHALL have port AddressIO, input, 9 bits: CPU IO address.
REQ-008 SHALL have port ReadIO, input, 1 bit: CPU read strobe, one cycle per access.
REQ-009 SHALL have port WriteIO, input, 1 bit: CPU write strobe, one cycle per access.
REQ-010 SHALL have port DataOutput, input, 32 bits: CPU write data.
REQ-011 SHALL have port DataInputTowardMicro, output, 32 bits: registered read data to the CPU.
REQ-012 SHALL have port Irq, output, 1 bit: registered level interrupt request.

Function
REQ-013 SHALL pass each pin through a two-flop synchronizer before any other use.
REQ-014 SHALL keep per bit a Stable bit and a debounce counter of clog2(DebounceCount+1) bits.
REQ-015 SHALL clear a bit's counter in any cycle where its synchronized value equals Stable.
REQ-016 SHALL increment the counter while the synchronized value differs from Stable; on the cycle the counter would reach DebounceCount it SHALL load Stable with the synchronized value and clear the counter.
REQ-017 SHALL therefore update Stable exactly 2+DebounceCount cycles after a clean pin transition; glitches shorter than DebounceCount synchronized cycles SHALL not change Stable.
REQ-018 SHALL set bit n of EdgeStatus in the cycle Stable[n] goes 0->1; falling edges SHALL not set status.
REQ-019 SHALL map registers: BaseAddress+0 = Stable (RO); BaseAddress+1 = EdgeStatus (write-1-to-clear); BaseAddress+2 = IrqEnable (RW, Width bits).
REQ-020 SHALL, on ReadIO with a mapped address, drive DataInputTowardMicro with the zero-extended register value on the following cycle (latency 1) and hold it until the next read.
REQ-021 SHALL drive DataInputTowardMicro to 0 the cycle after a read of an unmapped address.
REQ-022 SHALL ignore writes to BaseAddress+0 and unmapped addresses; bits of DataOutput above Width-1 SHALL be ignored.
REQ-023 SHALL, when an edge sets EdgeStatus[n] in the same cycle a write-1-to-clear targets bit n, leave EdgeStatus[n] = 1 (set wins).
REQ-024 SHALL, when ReadIO and WriteIO are both high in one cycle, perform both; read data SHALL reflect the pre-write value.
REQ-025 SHALL register Irq = OR-reduce(EdgeStatus & IrqEnable), one cycle behind those registers.

Reset
REQ-026 SHALL, while Reset is high at a clock edge, clear synchronizers, Stable, all counters, EdgeStatus, IrqEnable, DataInputTowardMicro and Irq to 0.
REQ-027 SHALL, when Reset is asserted mid-debounce, abandon the in-progress count; a pin held at 1 through reset release SHALL produce Stable = 1 and an EdgeStatus set 2+DebounceCount cycles after release.
REQ-028 SHALL ignore ReadIO and WriteIO during Reset cycles.

Verification
REQ-029 Reset release with pins = 0 -> all reads at BaseAddress+0..+2 return 32'h0, Irq = 0.
REQ-030 Pin 3 driven 0->1 and held, DebounceCount = 16 -> Stable[3] = 1 exactly 18 cycles later; read of BaseAddress+1 returns 32'h8.
REQ-031 Pin 5 pulsed high for 10 cycles (DebounceCount = 16) -> Stable and EdgeStatus stay 0, Irq stays 0.
REQ-032 Write 32'h8 to BaseAddress+2 after REQ-030 event -> Irq = 1 one cycle after write; write 32'h8 to BaseAddress+1 -> EdgeStatus = 0 and Irq falls one cycle later.
REQ-033 Rising edge on bit 0 coincident with write 32'h1 to BaseAddress+1 -> EdgeStatus[0] remains 1.
REQ-034 Read of BaseAddress+7 -> DataInputTowardMicro = 32'h0 the next cycle; Reset asserted mid-debounce -> counter cleared, Stable unchanged at 0.
